// File: rtl/game_pkg.sv
// Shared types and constants for the Flappy Bird round sequencer and score display.
package game_pkg;

  localparam int DIGIT_W = 4;
  localparam int SCORE_W = 3 * DIGIT_W;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 12'h999;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    DYING   = 2'd2,
    OVER    = 2'd3
  } state_e;

  // Digit-by-digit magnitude compare, most significant digit first.
  function automatic logic bcd_gt(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
    for (int i = 2; i >= 0; i--) begin
      if (a[i*DIGIT_W +: DIGIT_W] > b[i*DIGIT_W +: DIGIT_W]) return 1'b1;
      if (a[i*DIGIT_W +: DIGIT_W] < b[i*DIGIT_W +: DIGIT_W]) return 1'b0;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit BCD up-counter with synchronous clear; holds at 999 instead of wrapping.
module bcd_counter3
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [SCORE_W-1:0] count_o
);

  logic [SCORE_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != SCORE_MAX)) begin
      if (count_q[3:0] != 4'd9) begin
        count_d[3:0] = count_q[3:0] + 4'd1;
      end else begin
        count_d[3:0] = 4'd0;
        if (count_q[7:4] != 4'd9) begin
          count_d[7:4] = count_q[7:4] + 4'd1;
        end else begin
          count_d[7:4]  = 4'd0;
          count_d[11:8] = count_q[11:8] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/game_controller.sv
// Round sequencer: flap synchronizer, IDLE/PLAYING/DYING/OVER FSM, death timer and BCD score.
// Optional high-score register is built when HIGH_SCORE_EN is defined.
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned DEATH_CYCLES = 25_000_000,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flap_btn,
  input  logic               pipe_passed,
  input  logic               pipe_collision,
  input  logic               ground_hit,
  output logic               pipe_enable,
  output logic               round_reset,
  output logic               flap_pulse,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score_bcd
`ifdef HIGH_SCORE_EN
  ,
  output logic [SCORE_W-1:0] high_bcd
`endif
);

  localparam logic [25:0] DEATH_LOAD = 26'(DEATH_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   flap_edge_q;

  state_e      state_q, state_d;
  logic [25:0] death_cnt_q, death_cnt_d;
  logic        pipe_enable_q, pipe_enable_d;
  logic        flap_pulse_q, flap_pulse_d;
  logic        round_reset_q, round_reset_d;
  logic        score_inc;
  logic        death_evt;

  assign death_evt = pipe_collision | ground_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      flap_edge_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], flap_btn};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
      flap_edge_q <= sync_q[SYNC_STAGES-1] & ~sync_prev_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      death_cnt_q   <= '0;
      pipe_enable_q <= 1'b0;
      flap_pulse_q  <= 1'b0;
      round_reset_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      death_cnt_q   <= death_cnt_d;
      pipe_enable_q <= pipe_enable_d;
      flap_pulse_q  <= flap_pulse_d;
      round_reset_q <= round_reset_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    death_cnt_d = death_cnt_q;
    case (state_q)
      IDLE:    if (flap_edge_q) state_d = PLAYING;
      PLAYING: if (death_evt) begin
        state_d     = DYING;
        death_cnt_d = DEATH_LOAD;
      end
      DYING:   if (death_cnt_q == '0) state_d = OVER;
               else death_cnt_d = death_cnt_q - 26'd1;
      OVER:    if (flap_edge_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Death beats both a coincident flap and a coincident pipe pass.
  always_comb begin
    pipe_enable_d = (state_d == PLAYING);
    flap_pulse_d  = flap_edge_q & ((state_q == IDLE) | ((state_q == PLAYING) & ~death_evt));
    round_reset_d = flap_edge_q & (state_q == OVER);
    score_inc     = pipe_passed & (state_q == PLAYING) & ~death_evt;
  end

  bcd_counter3 u_score (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (round_reset_d),
    .inc_i   (score_inc),
    .count_o (score_bcd)
  );

`ifdef HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      high_q <= '0;
    end else if ((state_q == DYING) && (state_d == OVER) && bcd_gt(score_bcd, high_q)) begin
      high_q <= score_bcd;
    end
  end

  assign high_bcd = high_q;
`endif

  assign pipe_enable = pipe_enable_q;
  assign flap_pulse  = flap_pulse_q;
  assign round_reset = round_reset_q;
  assign state       = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller with DEATH_CYCLES=4, SYNC_STAGES=2.
module tb_game_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flap_btn = 1'b0;
  logic        pipe_passed = 1'b0;
  logic        pipe_collision = 1'b0;
  logic        ground_hit = 1'b0;
  logic        pipe_enable, round_reset, flap_pulse;
  logic [1:0]  state;
  logic [11:0] score_bcd;
`ifdef HIGH_SCORE_EN
  logic [11:0] high_bcd;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int score_m = 0;
  int high_m  = 0;
  logic [11:0] exp_q[$];

  game_controller #(.DEATH_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flap_btn       (flap_btn),
    .pipe_passed    (pipe_passed),
    .pipe_collision (pipe_collision),
    .ground_hit     (ground_hit),
    .pipe_enable    (pipe_enable),
    .round_reset    (round_reset),
    .flap_pulse     (flap_pulse),
    .state          (state),
    .score_bcd      (score_bcd)
`ifdef HIGH_SCORE_EN
    ,
    .high_bcd       (high_bcd)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pass_pulse();
    logic [11:0] e;
    @(negedge clk);
    pipe_passed = 1'b1;
    if (score_m < 999) score_m++;
    exp_q.push_back(to_bcd(score_m));
    tick();
    pipe_passed = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if (score_bcd !== e) begin n_fail++; $display("FAIL score_inc: got %h expected %h", score_bcd, e); end
  endtask

  task automatic press_release();
    @(negedge clk);
    flap_btn = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    flap_btn = 1'b0;
    repeat (4) tick();
  endtask

  task automatic wait_over();
    int k;
    k = 0;
    while (state !== 2'd3 && k < 12) begin tick(); k++; end
    n_tests++;
    if (state !== 2'd3) begin n_fail++; $display("FAIL wait_over: got state %0d expected 3", state); end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", state); end
    n_tests++; if (pipe_enable !== 1'b0) begin n_fail++; $display("FAIL rst_pipe_en: got %b expected 0", pipe_enable); end
    n_tests++; if (flap_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_flap: got %b expected 0", flap_pulse); end
    n_tests++; if (round_reset !== 1'b0) begin n_fail++; $display("FAIL rst_rr: got %b expected 0", round_reset); end
    n_tests++; if (score_bcd !== 12'h000) begin n_fail++; $display("FAIL rst_score: got %h expected 000", score_bcd); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) tick();
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_release_state: got %0d expected 0", state); end
  endtask

  task automatic test_flap_start();
    @(negedge clk);
    flap_btn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (state !== 2'd0 || flap_pulse !== 1'b0) begin n_fail++; $display("FAIL flap_latency_%0d: got state %0d pulse %b expected 0 0", i, state, flap_pulse); end
    end
    tick();
    n_tests++; if (flap_pulse !== 1'b1) begin n_fail++; $display("FAIL flap_pulse: got %b expected 1", flap_pulse); end
    n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL start_state: got %0d expected 1", state); end
    n_tests++; if (pipe_enable !== 1'b1) begin n_fail++; $display("FAIL start_pipe_en: got %b expected 1", pipe_enable); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++; if (flap_pulse !== 1'b0) begin n_fail++; $display("FAIL flap_held_%0d: got %b expected 0", i, flap_pulse); end
    end
    @(negedge clk);
    flap_btn = 1'b0;
    repeat (4) tick();
    score_m = 0;
  endtask

  task automatic test_score_ten();
    for (int i = 0; i < 10; i++) pass_pulse();
    n_tests++; if (score_bcd !== 12'h010) begin n_fail++; $display("FAIL score_ten: got %h expected 010", score_bcd); end
  endtask

  task automatic test_death_timing(input logic tie);
    @(negedge clk);
    ground_hit  = ~tie;
    pipe_collision = tie;
    pipe_passed = tie;
    tick();
    ground_hit = 1'b0; pipe_collision = 1'b0; pipe_passed = 1'b0;
    n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL death_state: got %0d expected 2", state); end
    n_tests++; if (pipe_enable !== 1'b0) begin n_fail++; $display("FAIL death_pipe_en: got %b expected 0", pipe_enable); end
    n_tests++; if (score_bcd !== to_bcd(score_m)) begin n_fail++; $display("FAIL death_score: got %h expected %h", score_bcd, to_bcd(score_m)); end
    for (int i = 1; i < 4; i++) begin
      tick();
      n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL dying_hold_%0d: got %0d expected 2", i, state); end
    end
    tick();
    n_tests++; if (state !== 2'd3) begin n_fail++; $display("FAIL over_entry: got %0d expected 3", state); end
    if (score_m > high_m) high_m = score_m;
`ifdef HIGH_SCORE_EN
    n_tests++; if (high_bcd !== to_bcd(high_m)) begin n_fail++; $display("FAIL high_update: got %h expected %h", high_bcd, to_bcd(high_m)); end
`endif
  endtask

  task automatic test_round_restart();
    @(negedge clk);
    flap_btn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (round_reset !== 1'b0 || state !== 2'd3) begin n_fail++; $display("FAIL restart_wait_%0d: got rr %b state %0d expected 0 3", i, round_reset, state); end
    end
    tick();
    n_tests++; if (round_reset !== 1'b1) begin n_fail++; $display("FAIL rr_pulse: got %b expected 1", round_reset); end
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL rr_state: got %0d expected 0", state); end
    n_tests++; if (score_bcd !== 12'h000) begin n_fail++; $display("FAIL rr_score: got %h expected 000", score_bcd); end
    n_tests++; if (flap_pulse !== 1'b0) begin n_fail++; $display("FAIL rr_no_flap: got %b expected 0", flap_pulse); end
    tick();
    n_tests++; if (round_reset !== 1'b0 || flap_pulse !== 1'b0) begin n_fail++; $display("FAIL rr_one_cycle: got rr %b pulse %b expected 0 0", round_reset, flap_pulse); end
    score_m = 0;
`ifdef HIGH_SCORE_EN
    n_tests++; if (high_bcd !== to_bcd(high_m)) begin n_fail++; $display("FAIL high_survives: got %h expected %h", high_bcd, to_bcd(high_m)); end
`endif
    @(negedge clk);
    flap_btn = 1'b0;
    ground_hit = 1'b1;
    pipe_passed = 1'b1;
    tick();
    @(negedge clk);
    pipe_passed = 1'b0;
    repeat (3) tick();
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL idle_ignores_hit: got %0d expected 0", state); end
    n_tests++; if (score_bcd !== 12'h000) begin n_fail++; $display("FAIL idle_ignores_pass: got %h expected 000", score_bcd); end
    @(negedge clk);
    ground_hit = 1'b0;
    tick();
  endtask

  task automatic start_round();
    press_release();
    n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL round_start: got %0d expected 1", state); end
  endtask

  task automatic play_round(input int n);
    start_round();
    for (int i = 0; i < n; i++) pass_pulse();
    @(negedge clk);
    pipe_collision = 1'b1;
    tick();
    @(negedge clk);
    pipe_collision = 1'b0;
    wait_over();
    if (score_m > high_m) high_m = score_m;
`ifdef HIGH_SCORE_EN
    n_tests++; if (high_bcd !== to_bcd(high_m)) begin n_fail++; $display("FAIL round_high: got %h expected %h", high_bcd, to_bcd(high_m)); end
`endif
    press_release();
    score_m = 0;
    n_tests++; if (state !== 2'd0 || score_bcd !== 12'h000) begin n_fail++; $display("FAIL round_end: got state %0d score %h expected 0 000", state, score_bcd); end
  endtask

  task automatic test_high_score();
    play_round(7);
    play_round(3);
    play_round(12);
`ifdef HIGH_SCORE_EN
    n_tests++; if (high_bcd !== 12'h012) begin n_fail++; $display("FAIL high_final: got %h expected 012", high_bcd); end
`endif
  endtask

  task automatic test_saturation();
    start_round();
    for (int i = 0; i < 998; i++) pass_pulse();
    n_tests++; if (score_bcd !== 12'h998) begin n_fail++; $display("FAIL sat_998: got %h expected 998", score_bcd); end
    pass_pulse();
    pass_pulse();
    pass_pulse();
    n_tests++; if (score_bcd !== 12'h999) begin n_fail++; $display("FAIL sat_hold: got %h expected 999", score_bcd); end
    test_death_timing(1'b0);
    press_release();
    score_m = 0;
  endtask

  task automatic test_async_reset();
    start_round();
    for (int i = 0; i < 4; i++) pass_pulse();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL async_state: got %0d expected 0", state); end
    n_tests++; if (score_bcd !== 12'h000) begin n_fail++; $display("FAIL async_score: got %h expected 000", score_bcd); end
    n_tests++; if (pipe_enable !== 1'b0 || flap_pulse !== 1'b0 || round_reset !== 1'b0) begin n_fail++; $display("FAIL async_ctrl: got en %b pulse %b rr %b expected 0 0 0", pipe_enable, flap_pulse, round_reset); end
`ifdef HIGH_SCORE_EN
    n_tests++; if (high_bcd !== 12'h000) begin n_fail++; $display("FAIL async_high: got %h expected 000", high_bcd); end
`endif
    score_m = 0;
    high_m = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) tick();
    n_tests++; if (state !== 2'd0 || round_reset !== 1'b0) begin n_fail++; $display("FAIL async_release: got state %0d rr %b expected 0 0", state, round_reset); end
  endtask

  initial begin
    test_reset();
    test_flap_start();
    test_score_ten();
    test_death_timing(1'b0);
    test_round_restart();
    start_round();
    for (int i = 0; i < 5; i++) pass_pulse();
    test_death_timing(1'b1);
    test_round_restart();
    test_high_score();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
